// File: rtl/dlx_pkg.sv
// Shared DLX types for the MEM stage: widths, bus FSM states and the
// request bundle captured when a load/store enters the memory stage.
package dlx_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    // One outstanding data-memory request as seen on the bus.
    typedef struct packed {
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  wdata;
        logic             we;
        logic             re;
        logic [REG_W-1:0] rd;
    } mem_req_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
// The memory answers a strobe with d_ready, carrying d_read_data for loads.
interface mem_stage_if #(
    parameter int XLEN = dlx_pkg::XLEN
);

    logic [XLEN-1:0] d_address;
    logic [XLEN-1:0] d_write_data;
    logic            d_write_enable;
    logic            d_read_enable;
    logic            d_ready;
    logic [XLEN-1:0] d_read_data;

    modport master (
        output d_address,
        output d_write_data,
        output d_write_enable,
        output d_read_enable,
        input  d_ready,
        input  d_read_data
    );

    modport slave (
        input  d_address,
        input  d_write_data,
        input  d_write_enable,
        input  d_read_enable,
        output d_ready,
        output d_read_data
    );

endinterface

// File: rtl/mem_bus_fsm.sv
// Bus sequencer of the MEM stage: accepts one request from IDLE, holds the
// bus registers stable in BUSY until d_ready or the wait limit, and reports
// stall plus single-cycle done/timeout pulses to the enclosing stage.
module mem_bus_fsm
    import dlx_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid_i,
    input  mem_req_t         req_i,
    mem_stage_if.master      dbus,
    output logic             stall_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic             is_load_o,
    output logic [REG_W-1:0] rd_o,
    output logic             bus_err_o
);

    localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_req_t         req_q, req_d;
    logic             bus_err_q, bus_err_d;
    logic             stall, done, timeout;

    // Next-state, wait counter and stall/done decode for the bus transaction.
    always_comb begin
        // NOTE: every signal written here gets a default first so that no path leaves it unassigned and infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        bus_err_d = bus_err_q;
        stall     = 1'b0;
        done      = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    stall   = 1'b1;
                    req_d   = req_i;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // The counter stops at the limit instead of wrapping.
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (dbus.d_ready || (cnt_q == CNT_LAST)) begin
                    done     = 1'b1;
                    timeout  = !dbus.d_ready;
                    req_d.we = 1'b0;
                    req_d.re = 1'b0;
                    state_d  = IDLE;
                    if (!dbus.d_ready) begin
                        bus_err_d = 1'b1;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, bus registers and sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Upstream must never see a stall while the stage is held in reset.
    assign stall_o   = reset_n & stall;
    assign done_o    = done;
    assign timeout_o = timeout;
    assign is_load_o = req_q.re;
    assign rd_o      = req_q.rd;
    assign bus_err_o = bus_err_q;

    assign dbus.d_address      = req_q.addr;
    assign dbus.d_write_data   = req_q.wdata;
    assign dbus.d_write_enable = req_q.we;
    assign dbus.d_read_enable  = req_q.re;

endmodule

// File: rtl/mem_stage.sv
// DLX MEM stage: forwards the EX result backward, builds the store operand
// (bypassing from WB), launches loads/stores on the data bus through
// mem_bus_fsm, and registers the results into WB.
module mem_stage
    import dlx_pkg::*;
#(
    parameter int XLEN     = dlx_pkg::XLEN,
    parameter int MAX_WAIT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [XLEN-1:0]  ALU_out_MEM,
    input  logic             d_write_enable_MEM,
    input  logic             d_load_enable_MEM,
    input  logic [REG_W-1:0] Rd_MEM,
    input  logic [REG_W-1:0] Rs2_MEM,
    output logic [REG_W-1:0] Rs2_rf,
    input  logic [XLEN-1:0]  S2_rf,
    output logic [XLEN-1:0]  ALU_out_MEM_backward,
    output logic [REG_W-1:0] Rd_MEM_backward,
    output logic             stall_MEM,
    mem_stage_if.master      dbus,
    output logic [XLEN-1:0]  ALU_out_WB,
    output logic [XLEN-1:0]  load_data_WB,
    output logic             d_load_enable_WB,
    output logic [REG_W-1:0] Rd_WB,
    output logic             bus_err
);

    logic             mem_op;
    logic [XLEN-1:0]  wb_value;
    logic [XLEN-1:0]  store_operand;
    mem_req_t         req;
    logic             done, timeout, is_load;
    logic [REG_W-1:0] rd_lat;

    logic [XLEN-1:0]  alu_wb_q, alu_wb_d;
    logic [XLEN-1:0]  load_data_wb_q, load_data_wb_d;
    logic             ld_wb_q, ld_wb_d;
    logic [REG_W-1:0] rd_wb_q, rd_wb_d;

    assign mem_op = d_write_enable_MEM | d_load_enable_MEM;

    assign Rs2_rf               = Rs2_MEM;
    assign ALU_out_MEM_backward = ALU_out_MEM;
    // A load's result is not ready yet, so it must not be forwarded from here.
    assign Rd_MEM_backward      = d_load_enable_MEM ? '0 : Rd_MEM;

    // Store data bypasses the regfile when the instruction in WB writes Rs2.
    always_comb begin
        wb_value      = ld_wb_q ? load_data_wb_q : alu_wb_q;
        store_operand = ((Rs2_MEM == rd_wb_q) && (rd_wb_q != '0)) ? wb_value : S2_rf;
    end

    // Request bundle; a store wins when both enables are (illegally) set.
    always_comb begin
        req       = '0;
        req.addr  = ALU_out_MEM;
        req.wdata = store_operand;
        req.we    = d_write_enable_MEM;
        req.re    = d_load_enable_MEM & ~d_write_enable_MEM;
        req.rd    = Rd_MEM;
    end

    mem_bus_fsm #(
        .MAX_WAIT (MAX_WAIT)
    ) u_bus_fsm (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid_i (mem_op),
        .req_i       (req),
        .dbus        (dbus),
        .stall_o     (stall_MEM),
        .done_o      (done),
        .timeout_o   (timeout),
        .is_load_o   (is_load),
        .rd_o        (rd_lat),
        .bus_err_o   (bus_err)
    );

    // WB register update: retire a finished access, bubble while stalled,
    // otherwise pass the ALU result straight through.
    always_comb begin
        alu_wb_d       = alu_wb_q;
        load_data_wb_d = load_data_wb_q;
        ld_wb_d        = 1'b0;
        rd_wb_d        = '0;
        if (done) begin
            if (is_load) begin
                rd_wb_d        = rd_lat;
                ld_wb_d        = 1'b1;
                load_data_wb_d = timeout ? '0 : dbus.d_read_data;
            end
        end else if (!stall_MEM) begin
            alu_wb_d = ALU_out_MEM;
            rd_wb_d  = Rd_MEM;
        end
    end

    // WB pipeline registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_wb_q       <= '0;
            load_data_wb_q <= '0;
            ld_wb_q        <= 1'b0;
            rd_wb_q        <= '0;
        end else begin
            alu_wb_q       <= alu_wb_d;
            load_data_wb_q <= load_data_wb_d;
            ld_wb_q        <= ld_wb_d;
            rd_wb_q        <= rd_wb_d;
        end
    end

    assign ALU_out_WB       = alu_wb_q;
    assign load_data_WB     = load_data_wb_q;
    assign d_load_enable_WB = ld_wb_q;
    assign Rd_WB            = rd_wb_q;

endmodule
